wfg_core_sync_gen: RTL and testbench
====================================

// Module: wfg_core_sync_gen
//
// PURPOSE
//   Timing generator of the waveform-generator core. It consumes the CFG.SUBCYCLE,
//   CFG.SYNC and CTRL.EN fields from the core register block and produces the
//   subcycle tick, the sync tick, a start pulse and a subcycle index. Downstream
//   stimulus/driver blocks use these outputs to pace every sample they emit.
//
// PARAMETERS
//   SUBCYCLEW  16  width of the subcycle period field and of the subcycle counter
//   SYNCW       8  width of the sync period field, the sync counter and subcycle_cnt_o
//
// PORTS
//   wb_clk_i             in   1          system clock; all logic on the rising edge
//   wb_rst_i             in   1          reset, asynchronous, active-high
//   cfg_subcycle_q_i     in   SUBCYCLEW  subcycle period minus 1, in clocks
//   cfg_sync_q_i         in   SYNCW      sync period minus 1, in subcycles
//   ctrl_en_q_i          in   1          core enable (level)
//   wfg_core_start_o     out  1          1-cycle pulse when a run starts
//   wfg_core_subcycle_o  out  1          1-cycle pulse at the end of each subcycle
//   wfg_core_sync_o      out  1          1-cycle pulse at the end of each sync period
//   wfg_core_subcycle_cnt_o out SYNCW    index of the current subcycle in the sync period
//   wfg_core_active_o    out  1          high while the FSM is in RUN
//
// BEHAVIOUR
//   - Reset (asynchronous, wb_rst_i=1):
//       state=IDLE; all counters and shadow registers = 0; every output = 0.
//   - State IDLE:
//       counters held at 0; all outputs 0.
//       Edge with ctrl_en_q_i=1: shadow_sub<=cfg_subcycle_q_i,
//       shadow_sync<=cfg_sync_q_i, sub_cnt<=0, sync_cnt<=0, state<=RUN,
//       wfg_core_start_o<=1 for exactly one cycle.
//   - State RUN, each edge with ctrl_en_q_i=1:
//       sub_cnt != shadow_sub: sub_cnt<=sub_cnt+1.
//       sub_cnt == shadow_sub: sub_cnt<=0, wfg_core_subcycle_o<=1 (one cycle).
//         sync_cnt != shadow_sync: sync_cnt<=sync_cnt+1.
//         sync_cnt == shadow_sync: sync_cnt<=0, wfg_core_sync_o<=1, and the shadows
//           reload from cfg_*_q_i. Config changes take effect only at sync boundaries.
//   - Periods:
//       subcycle = shadow_sub+1 clocks; sync = (shadow_sync+1)*(shadow_sub+1) clocks.
//       First subcycle pulse is registered shadow_sub+1 edges after the enable edge.
//       sync_o always coincides with a subcycle_o pulse.
//   - Degenerate settings:
//       shadow_sub=0: subcycle_o is high every cycle.
//       shadow_sync=0: sync_o on every subcycle.
//       Both 0: subcycle_o and sync_o are both high continuously.
//   - No overflow: the counters never exceed their shadow values; full-scale values
//     (all ones) give maximum periods with no wrap.
//   - Disable: an edge in RUN with ctrl_en_q_i=0 goes to IDLE, clears counters, and
//     drives all outputs to 0 on that edge. A pulse that would have fired is suppressed
//     (disable wins). Re-enable restarts from 0 with a fresh start pulse.
//   - wfg_core_subcycle_cnt_o = sync_cnt (registered).
//     wfg_core_active_o = (state==RUN).
//   - Reset asserted mid-run: outputs drop asynchronously; no pulse is issued after
//     reset is released until a new enable edge.
//
// TESTING
//   1. sub=3, sync=1, en 0->1:
//      start_o at +1 cycle; subcycle_o every 4 clocks; sync_o every 8 clocks;
//      subcycle_cnt_o runs 0,1,0,1.
//   2. sub=0, sync=0, enable:
//      subcycle_o and sync_o continuously high from the 1st edge; cnt stays 0.
//   3. sub=4, sync=2, write sub=1 mid-period:
//      period stays 5 clocks until the next sync_o, then becomes 2 clocks.
//   4. en dropped on the same edge sub_cnt==shadow_sub:
//      no subcycle_o pulse; active_o=0; re-enable gives start_o and a first tick after 5 clocks.
//   5. Assert wb_rst_i asynchronously mid-RUN:
//      all outputs 0 before the next clock edge; the FSM stays IDLE until en is sampled 1.
//   6. sub=16'hFFFF, sync=0:
//      subcycle_o period is exactly 65536 clocks, with no spurious pulse at counter wrap.

Source files
------------

// File: rtl/wfg_core_sync_gen_if.sv
// Bundle of configuration inputs and timing outputs for the waveform-generator sync generator.
// The master side drives configuration and enable; the slave side is the generator itself.
interface wfg_core_sync_gen_if #(
   parameter int unsigned SUBCYCLEW = 16,
   parameter int unsigned SYNCW     = 8
);
   logic [SUBCYCLEW-1:0] cfg_subcycle_q_i;
   logic [SYNCW-1:0]     cfg_sync_q_i;
   logic                 ctrl_en_q_i;
   logic                 wfg_core_start_o;
   logic                 wfg_core_subcycle_o;
   logic                 wfg_core_sync_o;
   logic [SYNCW-1:0]     wfg_core_subcycle_cnt_o;
   logic                 wfg_core_active_o;

   modport master (
      output cfg_subcycle_q_i,
      output cfg_sync_q_i,
      output ctrl_en_q_i,
      input  wfg_core_start_o,
      input  wfg_core_subcycle_o,
      input  wfg_core_sync_o,
      input  wfg_core_subcycle_cnt_o,
      input  wfg_core_active_o
   );

   modport slave (
      input  cfg_subcycle_q_i,
      input  cfg_sync_q_i,
      input  ctrl_en_q_i,
      output wfg_core_start_o,
      output wfg_core_subcycle_o,
      output wfg_core_sync_o,
      output wfg_core_subcycle_cnt_o,
      output wfg_core_active_o
   );
endinterface

// File: rtl/wfg_core_sync_gen.sv
// Subcycle/sync timing generator: paces downstream stimulus blocks with registered tick pulses.
// Period configuration is shadowed and only reloaded at sync boundaries.
//
// state    | meaning
// ST_IDLE  | disabled, counters cleared, all outputs low
// ST_RUN   | counting subcycles and sync periods
module wfg_core_sync_gen #(
   parameter int unsigned SUBCYCLEW = 16,
   parameter int unsigned SYNCW     = 8
) (
   input logic                wb_clk_i,
   input logic                wb_rst_i,
   wfg_core_sync_gen_if.slave sg
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [SUBCYCLEW-1:0] sub_cnt_q, sub_cnt_d;
   logic [SYNCW-1:0]     sync_cnt_q, sync_cnt_d;
   logic [SUBCYCLEW-1:0] shadow_sub_q, shadow_sub_d;
   logic [SYNCW-1:0]     shadow_sync_q, shadow_sync_d;
   logic                 start_q, start_d;
   logic                 subcycle_q, subcycle_d;
   logic                 sync_q, sync_d;

   always_comb begin
      state_d       = state_q;
      sub_cnt_d     = sub_cnt_q;
      sync_cnt_d    = sync_cnt_q;
      shadow_sub_d  = shadow_sub_q;
      shadow_sync_d = shadow_sync_q;
      start_d       = 1'b0;
      subcycle_d    = 1'b0;
      sync_d        = 1'b0;

      if (state_q == ST_IDLE) begin
         sub_cnt_d  = '0;
         sync_cnt_d = '0;
         if (sg.ctrl_en_q_i) begin
            shadow_sub_d  = sg.cfg_subcycle_q_i;
            shadow_sync_d = sg.cfg_sync_q_i;
            state_d       = ST_RUN;
            start_d       = 1'b1;
         end
      end else begin
         // Disable wins over any pulse that would fire on this edge.
         if (!sg.ctrl_en_q_i) begin
            state_d    = ST_IDLE;
            sub_cnt_d  = '0;
            sync_cnt_d = '0;
         end else if (sub_cnt_q != shadow_sub_q) begin
            sub_cnt_d = sub_cnt_q + SUBCYCLEW'(1);
         end else begin
            sub_cnt_d  = '0;
            subcycle_d = 1'b1;
            if (sync_cnt_q != shadow_sync_q) begin
               sync_cnt_d = sync_cnt_q + SYNCW'(1);
            end else begin
               sync_cnt_d    = '0;
               sync_d        = 1'b1;
               shadow_sub_d  = sg.cfg_subcycle_q_i;
               shadow_sync_d = sg.cfg_sync_q_i;
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q       <= ST_IDLE;
         sub_cnt_q     <= '0;
         sync_cnt_q    <= '0;
         shadow_sub_q  <= '0;
         shadow_sync_q <= '0;
         start_q       <= 1'b0;
         subcycle_q    <= 1'b0;
         sync_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         sub_cnt_q     <= sub_cnt_d;
         sync_cnt_q    <= sync_cnt_d;
         shadow_sub_q  <= shadow_sub_d;
         shadow_sync_q <= shadow_sync_d;
         start_q       <= start_d;
         subcycle_q    <= subcycle_d;
         sync_q        <= sync_d;
      end
   end

   assign sg.wfg_core_start_o        = start_q;
   assign sg.wfg_core_subcycle_o     = subcycle_q;
   assign sg.wfg_core_sync_o         = sync_q;
   assign sg.wfg_core_subcycle_cnt_o = sync_cnt_q;
   assign sg.wfg_core_active_o       = (state_q == ST_RUN);
endmodule

// File: tb/tb_wfg_core_sync_gen.sv
// Directed bench for the sync generator: hand-derived pulse schedules for each scenario.
module tb_wfg_core_sync_gen;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   spurious;

   wfg_core_sync_gen_if #(.SUBCYCLEW(16), .SYNCW(8)) sg ();

   wfg_core_sync_gen #(.SUBCYCLEW(16), .SYNCW(8)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .sg       (sg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic st, input logic sb, input logic sy,
                          input logic [7:0] cnt, input logic act);
      chk({tag, "_start"},    32'(sg.wfg_core_start_o),        32'(st));
      chk({tag, "_subcycle"}, 32'(sg.wfg_core_subcycle_o),     32'(sb));
      chk({tag, "_sync"},     32'(sg.wfg_core_sync_o),         32'(sy));
      chk({tag, "_cnt"},      32'(sg.wfg_core_subcycle_cnt_o), 32'(cnt));
      chk({tag, "_active"},   32'(sg.wfg_core_active_o),       32'(act));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      spurious = 0;
      rst = 1'b1;
      sg.cfg_subcycle_q_i = '0;
      sg.cfg_sync_q_i     = '0;
      sg.ctrl_en_q_i      = 1'b0;
      #2;
      chk_all("reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk_all("idle", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

      // Scenario 1: sub=3, sync=1
      sg.cfg_subcycle_q_i = 16'd3;
      sg.cfg_sync_q_i     = 8'd1;
      sg.ctrl_en_q_i      = 1'b1;
      tick();
      chk_all("t1_en", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk_all("t1_run", 1'b0, (k % 4) == 0, (k % 8) == 0, 8'((k / 4) % 2), 1'b1);
      end
      sg.ctrl_en_q_i = 1'b0;
      tick();
      chk_all("t1_dis", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

      // Scenario 2: both periods zero
      sg.cfg_subcycle_q_i = 16'd0;
      sg.cfg_sync_q_i     = 8'd0;
      sg.ctrl_en_q_i      = 1'b1;
      tick();
      chk_all("t2_en", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk_all("t2_run", 1'b0, 1'b1, 1'b1, 8'd0, 1'b1);
      end
      sg.ctrl_en_q_i = 1'b0;
      tick();
      chk_all("t2_dis", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

      // Scenario 3: sub=4, sync=2, then sub=1 written mid-period
      sg.cfg_subcycle_q_i = 16'd4;
      sg.cfg_sync_q_i     = 8'd2;
      sg.ctrl_en_q_i      = 1'b1;
      tick();
      chk_all("t3_en", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (k <= 15)
            chk_all("t3_old", 1'b0, (k % 5) == 0, k == 15, 8'((k / 5) % 3), 1'b1);
         else
            chk_all("t3_new", 1'b0, ((k - 15) % 2) == 0, k == 21, 8'(((k - 15) / 2) % 3), 1'b1);
         if (k == 2) sg.cfg_subcycle_q_i = 16'd1;
      end
      sg.ctrl_en_q_i = 1'b0;
      tick();
      chk_all("t3_dis", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

      // Scenario 4: disable on the edge that would tick
      sg.cfg_subcycle_q_i = 16'd4;
      sg.cfg_sync_q_i     = 8'd0;
      sg.ctrl_en_q_i      = 1'b1;
      tick();
      chk_all("t4_en", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk_all("t4_pre", 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      end
      sg.ctrl_en_q_i = 1'b0;
      tick();
      chk_all("t4_supp", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      sg.ctrl_en_q_i = 1'b1;
      tick();
      chk_all("t4_reen", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk_all("t4_run", 1'b0, k == 5, k == 5, 8'd0, 1'b1);
      end
      sg.ctrl_en_q_i = 1'b0;
      tick();

      // Scenario 5: asynchronous reset mid-run
      sg.cfg_subcycle_q_i = 16'd2;
      sg.cfg_sync_q_i     = 8'd0;
      sg.ctrl_en_q_i      = 1'b1;
      tick();
      tick();
      tick();
      tick();
      chk_all("t5_pulse", 1'b0, 1'b1, 1'b1, 8'd0, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk_all("t5_async", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      sg.ctrl_en_q_i = 1'b0;
      #2 rst = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk_all("t5_idle", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      end
      sg.ctrl_en_q_i = 1'b1;
      tick();
      chk_all("t5_restart", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
      sg.ctrl_en_q_i = 1'b0;
      tick();

      // Scenario 6: full-scale subcycle period
      sg.cfg_subcycle_q_i = 16'hFFFF;
      sg.cfg_sync_q_i     = 8'd0;
      sg.ctrl_en_q_i      = 1'b1;
      tick();
      chk_all("t6_en", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
      for (int k = 1; k <= 65535; k++) begin
         tick();
         if (sg.wfg_core_subcycle_o || sg.wfg_core_sync_o) spurious++;
      end
      chk("t6_no_early_pulse", 32'(spurious), 32'd0);
      tick();
      chk_all("t6_tick", 1'b0, 1'b1, 1'b1, 8'd0, 1'b1);
      tick();
      chk_all("t6_after", 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      sg.ctrl_en_q_i = 1'b0;
      tick();
      chk_all("t6_dis", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
